// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-aligned fetches, buffers in-order responses
// in a small prefetch FIFO and feeds the IF/ID register, discarding stale responses after a redirect.
package fetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } if_id_t;
endpackage

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              take_branch,
    input  logic [31:0]       branch_target,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [31:0]       imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output fetch_pkg::if_id_t if_id,
    output logic              if_id_valid
);
    import fetch_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]      fetch_pc;
    logic [31:0]      rsp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] fifo_count;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    if_id_t           fifo_mem [FIFO_DEPTH];
    logic [CNT_W:0]   in_use;
    logic             accept;
    logic             dropping;
    logic             push;
    logic             pop;

    function automatic if_id_t bubble();
        bubble = '{pc: 32'h0, pc_plus4: 32'h0, instr: NOP};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Outstanding requests plus buffered entries are capped so every response has a slot.
    assign in_use         = (CNT_W+1)'(outstanding) + (CNT_W+1)'(fifo_count);
    assign imem_req_valid = reset_n && !take_branch && (in_use < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign dropping       = imem_rsp_valid && (drop_cnt != '0);
    assign push           = imem_rsp_valid && (drop_cnt == '0) && !take_branch;
    assign pop            = !take_branch && !stall && (fifo_count != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            head        <= '0;
            tail        <= '0;
            if_id       <= bubble();
            if_id_valid <= 1'b0;
        end else begin
            case ({accept, imem_rsp_valid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            if (take_branch) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc    <= {branch_target[31:2], 2'b00};
                rsp_pc      <= {branch_target[31:2], 2'b00};
                drop_cnt    <= outstanding - CNT_W'(imem_rsp_valid);
                fifo_count  <= '0;
                head        <= '0;
                tail        <= '0;
                if_id       <= bubble();
                if_id_valid <= 1'b0;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + 32'd4;
                if (dropping)
                    drop_cnt <= drop_cnt - 1'b1;
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    tail   <= ptr_inc(tail);
                end
                if (pop)
                    head <= ptr_inc(head);
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + 1'b1;
                    2'b01:   fifo_count <= fifo_count - 1'b1;
                    default: fifo_count <= fifo_count;
                endcase
                if (!stall) begin
                    if (fifo_count != '0) begin
                        if_id       <= fifo_mem[head];
                        if_id_valid <= 1'b1;
                    end else begin
                        if_id       <= bubble();
                        if_id_valid <= 1'b0;
                    end
                end
            end
        end
    end

    // Storage needs no reset: fifo_count gates every read.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[tail] <= '{pc: rsp_pc, pc_plus4: rsp_pc + 32'd4, instr: imem_rsp_data};
    end
endmodule
